sr_fetch_stage: RTL and testbench

//   Instruction-fetch stage of the pipelined schoolRISCV core; feeds the decode stage.

---
 rtl/sr_fetch_stage.sv | 150 +++++++++++++++
 tb/tb_sr_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sr_fetch_stage.sv
// Instruction-fetch stage of the pipelined schoolRISCV core: owns the PC, drives the
// combinational instruction memory, fills IF/ID and halts fetch behind each B-type branch.
module sr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned BR_TIMEOUT = 8,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imAddr,
  input  logic [31:0] imData,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        br_resolve_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcPlus4_o,
  output logic        valid_o,
  output logic        br_wait_o,
  output logic        timeout_err_o
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_WAIT_BR = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST   = 8'(BR_TIMEOUT - 1);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        valid_q, valid_d;
  logic        br_wait_q, br_wait_d;
  logic        err_q, err_d;

  logic        is_br_s;
  logic        advance_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] br_target_s;

  assign is_br_s     = (imData[6:0] == OPC_BRANCH);
  assign advance_s   = ~stall_i | flush_i;
  assign pc_plus4_s  = pc_q + 32'd4;
  assign br_target_s = {br_target_i[31:2], 2'b00};

  // PC, branch-wait FSM, timeout counter and sticky error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (advance_s) begin
          if (is_br_s) begin
            state_d = ST_WAIT_BR;
            cnt_d   = 8'd0;
          end else begin
            pc_d = pc_plus4_s;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      ST_WAIT_BR: begin
        // Resolve and timeout act regardless of stall; only IF/ID honours stall
        if (br_resolve_i) begin
          pc_d    = br_taken_i ? br_target_s : pc_plus4_s;
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          pc_d    = pc_plus4_s;
          err_d   = 1'b1;
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 8'd0;
      end
    endcase
    br_wait_d = (state_d == ST_WAIT_BR);
  end

  // IF/ID register: flush beats stall beats load; waiting on a branch loads bubbles
  always_comb begin
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    valid_d  = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (state_q == ST_RUN) begin
      instr_d  = imData;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4_s;
      valid_d  = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= 8'd0;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      id_pc_q   <= 32'd0;
      id_pc4_q  <= 32'd0;
      valid_q   <= 1'b0;
      br_wait_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      id_pc_q   <= id_pc_d;
      id_pc4_q  <= id_pc4_d;
      valid_q   <= valid_d;
      br_wait_q <= br_wait_d;
      err_q     <= err_d;
    end
  end

  assign imAddr        = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = id_pc_q;
  assign pcPlus4_o     = id_pc4_q;
  assign valid_o       = valid_q;
  assign br_wait_o     = br_wait_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_sr_fetch_stage.sv
// Scoreboard bench for sr_fetch_stage: directed steps push the hand-derived post-edge
// state into a queue; a negedge monitor pops and compares.
module tb_sr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BRW = 32'h0000_0063;

  logic        clk;
  logic        rst_n;
  logic [31:0] imAddr, imData;
  logic        stall, flush, res, taken;
  logic [31:0] tgt;
  logic [31:0] instr, pc, pc4;
  logic        valid, bw, err;
  logic [31:0] br_addr;

  logic        w_stall;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;
  logic        w_valid, w_bw, w_err;

  typedef struct {
    logic [31:0] addr, instr, pc, pc4;
    logic        v, bw, err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_fail;

  function automatic logic [31:0] alu(input logic [31:0] a);
    return {a[11:0], 20'h00093};
  endfunction

  assign imData = (imAddr == br_addr) ? BRW : alu(imAddr);

  sr_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imAddr(imAddr), .imData(imData),
    .stall_i(stall), .flush_i(flush), .br_resolve_i(res), .br_taken_i(taken),
    .br_target_i(tgt), .instr_o(instr), .pc_o(pc), .pcPlus4_o(pc4),
    .valid_o(valid), .br_wait_o(bw), .timeout_err_o(err)
  );

  sr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imAddr(w_addr), .imData(NOP),
    .stall_i(w_stall), .flush_i(1'b0), .br_resolve_i(1'b0), .br_taken_i(1'b0),
    .br_target_i(32'd0), .instr_o(w_instr), .pc_o(w_pc), .pcPlus4_o(w_pc4),
    .valid_o(w_valid), .br_wait_o(w_bw), .timeout_err_o(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, i, p, p4, input logic v, b, e);
    exp_t x;
    x.addr = a; x.instr = i; x.pc = p; x.pc4 = p4; x.v = v; x.bw = b; x.err = e;
    sb_q.push_back(x);
  endtask

  // Drive one cycle of inputs, clock it, and queue the expected post-edge state
  task automatic step(input logic s, f, r, t, input logic [31:0] target,
                      input logic [31:0] a, i, p, p4, input logic v, b, e);
    stall = s; flush = f; res = r; taken = t; tgt = target;
    @(posedge clk);
    push_exp(a, i, p, p4, v, b, e);
    #1;
    stall = 1'b0; flush = 1'b0; res = 1'b0; taken = 1'b0; tgt = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  // Monitor: the DUT presents its IF state every cycle; compare against the oldest entry
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      chk("imAddr", imAddr, x.addr);
      chk("instr_o", instr, x.instr);
      chk("pc_o", pc, x.pc);
      chk("pcPlus4_o", pc4, x.pc4);
      chk1("valid_o", valid, x.v);
      chk1("br_wait_o", bw, x.bw);
      chk1("timeout_err_o", err, x.err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; res = 1'b0; taken = 1'b0; tgt = 32'd0;
    br_addr = 32'hFFFF_FFFF; w_stall = 1'b1;
    #1 rst_n = 1'b0;
    push_exp(32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("wrap reset imAddr", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Straight-line fetch; wrap instance advances once alongside
    w_stall = 1'b0;
    step(0,0,0,0,32'h0, 32'h4,  alu(32'h0), 32'h0, 32'h4,  1,0,0);
    w_stall = 1'b1;
    chk("wrap imAddr", w_addr, 32'h0);
    chk("wrap pc_o", w_pc, 32'hFFFF_FFFC);
    chk("wrap pcPlus4_o", w_pc4, 32'h0);
    chk1("wrap valid_o", w_valid, 1'b1);
    step(0,0,0,0,32'h0, 32'h8,  alu(32'h4), 32'h4, 32'h8,  1,0,0);
    step(0,0,0,0,32'h0, 32'hC,  alu(32'h8), 32'h8, 32'hC,  1,0,0);
    step(0,0,0,0,32'h0, 32'h10, alu(32'hC), 32'hC, 32'h10, 1,0,0);

    // Branch at 0x8, taken to 0x43 (low bits dropped) on the second wait cycle
    br_addr = 32'h8;
    do_reset();
    step(0,0,0,0,32'h0,  32'h4,  alu(32'h0), 32'h0, 32'h4,  1,0,0);
    step(0,0,0,0,32'h0,  32'h8,  alu(32'h4), 32'h4, 32'h8,  1,0,0);
    step(0,0,0,0,32'h0,  32'h8,  BRW,        32'h8, 32'hC,  1,1,0);
    step(0,0,0,0,32'h0,  32'h8,  NOP,        32'h8, 32'hC,  0,1,0);
    step(0,0,1,1,32'h43, 32'h40, NOP,        32'h8, 32'hC,  0,0,0);
    step(0,0,0,0,32'h0,  32'h44, alu(32'h40),32'h40,32'h44, 1,0,0);

    // Not-taken resolve coinciding with stall
    do_reset();
    step(0,0,0,0,32'h0,  32'h4,  alu(32'h0), 32'h0, 32'h4,  1,0,0);
    step(0,0,0,0,32'h0,  32'h8,  alu(32'h4), 32'h4, 32'h8,  1,0,0);
    step(0,0,0,0,32'h0,  32'h8,  BRW,        32'h8, 32'hC,  1,1,0);
    step(1,0,1,0,32'h40, 32'hC,  BRW,        32'h8, 32'hC,  1,0,0);
    step(0,0,0,0,32'h0,  32'h10, alu(32'hC), 32'hC, 32'h10, 1,0,0);

    // Timeout: eight wait cycles (one stalled) then forced fall-through
    do_reset();
    step(0,0,0,0,32'h0, 32'h4, alu(32'h0), 32'h0, 32'h4, 1,0,0);
    step(0,0,0,0,32'h0, 32'h8, alu(32'h4), 32'h4, 32'h8, 1,0,0);
    step(0,0,0,0,32'h0, 32'h8, BRW,        32'h8, 32'hC, 1,1,0);
    for (int i = 1; i <= 7; i++) begin
      step((i == 2), 0,0,0,32'h0, 32'h8, NOP, 32'h8, 32'hC, 0,1,0);
    end
    step(0,0,0,0,32'h0, 32'hC,  NOP,        32'h8, 32'hC,  0,0,1);
    step(0,0,0,0,32'h0, 32'h10, alu(32'hC), 32'hC, 32'h10, 1,0,1);

    // Stall freeze, flush (with stall) bubble, flush over a branch
    for (int i = 0; i < 3; i++) begin
      step(1,0,0,0,32'h0, 32'h10, alu(32'hC), 32'hC, 32'h10, 1,0,1);
    end
    step(0,0,0,0,32'h0,  32'h14, alu(32'h10), 32'h10, 32'h14, 1,0,1);
    step(1,1,0,0,32'h0,  32'h18, NOP,         32'h10, 32'h14, 0,0,1);
    step(0,0,0,0,32'h0,  32'h1C, alu(32'h18), 32'h18, 32'h1C, 1,0,1);
    br_addr = 32'h1C;
    step(0,1,0,0,32'h0,  32'h1C, NOP,         32'h18, 32'h1C, 0,1,1);
    step(0,0,1,1,32'h80, 32'h80, NOP,         32'h18, 32'h1C, 0,0,1);

    // Asynchronous reset while waiting on a branch
    br_addr = 32'h84;
    step(0,0,0,0,32'h0, 32'h84, alu(32'h80), 32'h80, 32'h84, 1,0,1);
    step(0,0,0,0,32'h0, 32'h84, BRW,         32'h84, 32'h88, 1,1,1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async imAddr", imAddr, 32'h0);
    chk("async instr_o", instr, NOP);
    chk("async pc_o", pc, 32'h0);
    chk1("async valid_o", valid, 1'b0);
    chk1("async br_wait_o", bw, 1'b0);
    chk1("async timeout_err_o", err, 1'b0);
    chk("async wrap imAddr", w_addr, 32'hFFFF_FFFC);
    #1 rst_n = 1'b1;
    step(0,0,0,0,32'h0, 32'h4, alu(32'h0), 32'h0, 32'h4, 1,0,0);

    @(negedge clk);
    #1;
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
